narnet_param_engine: RTL and testbench
======================================

NARNET_PARAM_ENGINE -- requirements
Module: narnet_param_engine

Interface
REQ-001 Parameter DW, 8, signed fixed-point data width.
REQ-002 Parameter FRAC, 6, fractional bits.
REQ-003 Parameter N_NEUR, 5, hidden-layer neuron count (1..16).
REQ-004 Parameter DELAYS, 16, tap-delay-line depth (2..64).
REQ-005 Parameter INIT_VAL, 24, delay-line reset value (0.375 in S.6).
REQ-006 clk  in  1  clock.
REQ-007 rst  in  1  synchronous, active-high reset.
REQ-008 x_valid  in  1  input sample valid.
REQ-009 x_data  in  DW  signed input sample.
REQ-010 x_ready  out  1  engine idle and accepting a sample.
REQ-011 y_valid  out  1  prediction valid.
REQ-012 y_data  out  DW  signed prediction.
REQ-013 y_ready  in  1  downstream accepts the prediction.
REQ-014 w_addr  out  clog2(DELAYS+3)  weight ROM address.
REQ-015 w_data  in  N_NEUR*DW  weight ROM row, lane i = neuron i; 1-cycle read latency.
REQ-016 t_addr  out  DW  tanh LUT address (pre-activation bit pattern).
REQ-017 t_data  in  DW  tanh LUT value; 1-cycle read latency.

Function
REQ-018 ROM map: rows 0..DELAYS-1 hold layer-1 tap weights; row DELAYS holds layer-1 biases; row DELAYS+1 holds layer-2 weights; row DELAYS+2, lane 0, holds the layer-2 bias.
REQ-019 States: IDLE, LOAD, L1, ACT, L2, OUT.
REQ-020 x_ready SHALL be 1 only in IDLE; a sample transfers on x_valid&&x_ready.
REQ-021 LOAD (1 cycle) SHALL write the accepted sample into a circular delay line at the write pointer, which wraps from DELAYS-1 to 0.
REQ-022 Tap k (0..DELAYS-1) SHALL be the sample accepted k transfers before the current one; tap 0 is the current sample.
REQ-023 L1 (DELAYS+2 cycles): load biases into the accumulators, then accumulate one tap per cycle into all N_NEUR accumulators in parallel.
REQ-024 Each product SHALL be the DW x DW signed product, arithmetically shifted right by FRAC (truncation).
REQ-025 Accumulators SHALL be DW+clog2(DELAYS+1)+1 bits wide.
REQ-026 At the end of L1, each accumulator SHALL be reduced to DW bits per REQ-040/041.
REQ-027 ACT (N_NEUR+1 cycles): issue t_addr for each neuron in turn and capture t_data one cycle later.
REQ-028 L2 (3 cycles): compute the layer-2 bias plus the sum of products of layer-2 weights and activations, then reduce the result to DW bits.
REQ-029 Latency SHALL be DELAYS+N_NEUR+7 cycles from the transfer cycle to y_valid rising (28 at defaults).
REQ-030 In OUT, y_valid=1 and y_data SHALL be held stable until y_ready=1; the engine then returns to IDLE on the next cycle.
REQ-031 x_valid asserted outside IDLE SHALL be ignored; no sample is lost, since x_ready is 0.

Reset
REQ-032 Reset values: x_ready=1, y_valid=0, y_data=0, w_addr=0, t_addr=0, state=IDLE, write pointer=0.
REQ-033 All delay-line entries SHALL reset to INIT_VAL.
REQ-034 Reset asserted in any state SHALL abort the computation within the same clock edge; no y_valid is produced for the aborted sample.

Configuration
REQ-040 With NARNET_SAT_EN defined, every reduction to DW bits SHALL saturate to [-2^(DW-1), 2^(DW-1)-1].
REQ-041 With NARNET_SAT_EN undefined, every reduction SHALL keep the low DW bits (two's-complement wrap).

Structure
REQ-050 Package narnet_pkg SHALL hold the state enum, ROM row-offset constants, and the sat/wrap reduction function.
REQ-051 A sub-module narnet_mac (one signed multiply-shift-accumulate lane) SHALL be instantiated N_NEUR times via generate.

Verification
REQ-060 ROM all zero, LUT identity, x=64 -> y_data=0, y_valid on cycle 28.
REQ-061 Layer-1 biases 64, LUT identity, layer-2 weights 64 in all lanes, layer-2 bias 0, x=0, all tap weights 0 -> y_data=5*64*64>>6=320; saturates to 127 with NARNET_SAT_EN, otherwise wraps to 64.
REQ-062 y_ready held 0 for 10 cycles after y_valid -> y_valid and y_data stable, x_ready=0 throughout.
REQ-063 Feed 40 samples 1..40; tap-0 weight only =64 (1.0), LUT identity, layer-2 lane 0 =64, other lanes 0 -> each y_data equals its input sample, and the write pointer wraps correctly past DELAYS.
REQ-064 Tap-(DELAYS-1) weight only =64 -> first 15 outputs equal INIT_VAL=24; the 16th output equals sample 1.
REQ-065 rst pulsed on L1 cycle 5 -> no y_valid, x_ready=1 the next cycle, and the next result uses a delay line reset to INIT_VAL.

Source files
------------

// File: rtl/narnet_pkg.sv
// Shared types and helpers for the NARX network engine.
// NARNET_SAT_EN selects saturating (defined) or wrapping (undefined) reductions.
package narnet_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_L1,
      S_ACT,
      S_L2,
      S_OUT
   } narnet_state_t;

   // ROM rows after the DELAYS tap rows
   localparam int unsigned ROW_BIAS_OFS = 0;
   localparam int unsigned ROW_L2W_OFS  = 1;
   localparam int unsigned ROW_L2B_OFS  = 2;

   function automatic logic signed [31:0] narnet_reduce(input logic signed [31:0] v,
                                                         input int unsigned dw);
      logic signed [31:0] r;
`ifdef NARNET_SAT_EN
      logic signed [31:0] hi;
      logic signed [31:0] lo;
      hi = (32'sd1 <<< (dw - 1)) - 32'sd1;
      lo = -(32'sd1 <<< (dw - 1));
      if (v > hi)
         r = hi;
      else if (v < lo)
         r = lo;
      else
         r = v;
`else
      r = (v <<< (32 - dw)) >>> (32 - dw);
`endif
      return r;
   endfunction

endpackage

// File: rtl/narnet_mac.sv
// One signed multiply / shift-right-by-FRAC / accumulate lane.
// load replaces the accumulator with init; en adds the shifted product (both may combine).
module narnet_mac #(
   parameter int DW   = 8,
   parameter int FRAC = 6,
   parameter int AW   = 14
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 load,
   input  logic                 en,
   input  logic signed [DW-1:0] init,
   input  logic signed [DW-1:0] a,
   input  logic signed [DW-1:0] b,
   output logic signed [AW-1:0] acc
);

   logic signed [2*DW-1:0] prod;
   logic signed [AW-1:0]   term;
   logic signed [AW-1:0]   base;

   always_comb begin
      prod = a * b;
      term = en ? AW'(prod >>> FRAC) : '0;
      base = load ? AW'(init) : acc;
   end

   always_ff @(posedge clk) begin
      if (rst)
         acc <= '0;
      else if (load || en)
         acc <= base + term;
   end

endmodule

// File: rtl/narnet_param_engine.sv
// Single-sample NARX predictor: tap delay line -> N_NEUR tanh neurons -> linear output.
// Build with NARNET_SAT_EN defined for saturating reductions, otherwise they wrap.
module narnet_param_engine
   import narnet_pkg::*;
#(
   parameter int DW       = 8,
   parameter int FRAC     = 6,
   parameter int N_NEUR   = 5,
   parameter int DELAYS   = 16,
   parameter int INIT_VAL = 24
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          x_valid,
   input  logic [DW-1:0]                 x_data,
   output logic                          x_ready,
   output logic                          y_valid,
   output logic [DW-1:0]                 y_data,
   input  logic                          y_ready,
   output logic [$clog2(DELAYS+3)-1:0]   w_addr,
   input  logic [N_NEUR*DW-1:0]          w_data,
   output logic [DW-1:0]                 t_addr,
   input  logic [DW-1:0]                 t_data
);

   localparam int AW  = DW + $clog2(DELAYS + 1) + 1;
   localparam int WAW = $clog2(DELAYS + 3);
   localparam int PW  = $clog2(DELAYS);
   localparam int CW  = $clog2(DELAYS + N_NEUR + 4);
   localparam logic [WAW-1:0] ROW_BIAS = WAW'(DELAYS + ROW_BIAS_OFS);
   localparam logic [WAW-1:0] ROW_L2W  = WAW'(DELAYS + ROW_L2W_OFS);
   localparam logic [WAW-1:0] ROW_L2B  = WAW'(DELAYS + ROW_L2B_OFS);

   narnet_state_t        state;
   logic [DW-1:0]        dline [DELAYS];
   logic [DW-1:0]        act   [N_NEUR];
   logic signed [AW-1:0] acc   [N_NEUR];
   logic [PW-1:0]        wptr;
   logic [PW-1:0]        tap_idx;
   logic [CW-1:0]        cnt;
   logic [DW-1:0]        x_reg;
   logic signed [31:0]   l2_sum;
   logic signed [31:0]   l2_sum_c;
   logic [DW-1:0]        pre_sel;
   logic                 in_l2;
   logic                 lane_load;
   logic                 lane_en;

   function automatic logic [DW-1:0] red_acc(input logic signed [AW-1:0] v);
      logic signed [31:0] r;
      r = narnet_reduce(32'(v), DW);
      return r[DW-1:0];
   endfunction

   function automatic logic [DW-1:0] red_32(input logic signed [31:0] v);
      logic signed [31:0] r;
      r = narnet_reduce(v, DW);
      return r[DW-1:0];
   endfunction

   // L1 cnt 0 loads biases, cnt 1..DELAYS add taps; L2 cnt 0 forms products from zero
   always_comb begin
      in_l2     = (state == S_L2);
      lane_load = (state == S_L1 || in_l2) && (cnt == '0);
      lane_en   = (state == S_L1 && cnt != '0 && cnt <= CW'(DELAYS)) || (in_l2 && cnt == '0);
   end

   for (genvar i = 0; i < N_NEUR; i++) begin : g_lane
      logic [DW-1:0] w_lane;
      assign w_lane = w_data[i*DW +: DW];
      narnet_mac #(
         .DW   (DW),
         .FRAC (FRAC),
         .AW   (AW)
      ) u_mac (
         .clk  (clk),
         .rst  (rst),
         .load (lane_load),
         .en   (lane_en),
         .init (in_l2 ? '0 : w_lane),
         .a    (in_l2 ? act[i] : dline[tap_idx]),
         .b    (w_lane),
         .acc  (acc[i])
      );
   end

   // Next neuron whose pre-activation goes out on t_addr
   always_comb begin
      int unsigned sel;
      sel     = (state == S_ACT) ? 32'(cnt) + 32'd1 : 32'd0;
      pre_sel = red_acc(acc[0]);
      for (int unsigned i = 0; i < N_NEUR; i++)
         if (i == sel)
            pre_sel = red_acc(acc[i]);
   end

   always_comb begin
      l2_sum_c = 32'($signed(w_data[DW-1:0]));
      for (int unsigned i = 0; i < N_NEUR; i++)
         l2_sum_c = l2_sum_c + 32'(acc[i]);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= S_IDLE;
         x_ready <= 1'b1;
         y_valid <= 1'b0;
         y_data  <= '0;
         w_addr  <= '0;
         t_addr  <= '0;
         wptr    <= '0;
         tap_idx <= '0;
         cnt     <= '0;
         x_reg   <= '0;
         l2_sum  <= '0;
         for (int unsigned k = 0; k < DELAYS; k++)
            dline[k] <= DW'(INIT_VAL);
         for (int unsigned i = 0; i < N_NEUR; i++)
            act[i] <= '0;
      end else begin
         unique case (state)
            S_IDLE: begin
               if (x_valid) begin
                  x_reg   <= x_data;
                  x_ready <= 1'b0;
                  w_addr  <= ROW_BIAS;
                  state   <= S_LOAD;
               end
            end
            S_LOAD: begin
               dline[wptr] <= x_reg;
               tap_idx     <= wptr;
               wptr        <= (wptr == PW'(DELAYS - 1)) ? '0 : wptr + 1'b1;
               w_addr      <= '0;
               cnt         <= '0;
               state       <= S_L1;
            end
            S_L1: begin
               cnt <= cnt + 1'b1;
               if (cnt != '0)
                  tap_idx <= (tap_idx == '0) ? PW'(DELAYS - 1) : tap_idx - 1'b1;
               if (cnt < CW'(DELAYS - 1))
                  w_addr <= WAW'(cnt + 1'b1);
               if (cnt == CW'(DELAYS + 1)) begin
                  t_addr <= pre_sel;
                  w_addr <= ROW_L2W;
                  cnt    <= '0;
                  state  <= S_ACT;
               end
            end
            S_ACT: begin
               t_addr <= pre_sel;
               cnt    <= cnt + 1'b1;
               for (int unsigned i = 0; i < N_NEUR; i++)
                  if (cnt == CW'(i + 1))
                     act[i] <= t_data;
               if (cnt == CW'(N_NEUR)) begin
                  w_addr <= ROW_L2B;
                  cnt    <= '0;
                  state  <= S_L2;
               end
            end
            S_L2: begin
               cnt <= cnt + 1'b1;
               if (cnt == CW'(1))
                  l2_sum <= l2_sum_c;
               if (cnt == CW'(2)) begin
                  y_data  <= red_32(l2_sum);
                  y_valid <= 1'b1;
                  state   <= S_OUT;
               end
            end
            S_OUT: begin
               if (y_ready) begin
                  y_valid <= 1'b0;
                  x_ready <= 1'b1;
                  state   <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_narnet_param_engine.sv
// Directed + randomized bench for narnet_param_engine with a tap-history reference model.
module tb_narnet_param_engine;

   localparam int DW       = 8;
   localparam int FRAC     = 6;
   localparam int N_NEUR   = 5;
   localparam int DELAYS   = 16;
   localparam int INIT_VAL = 24;
   localparam int WAW      = $clog2(DELAYS + 3);
   localparam int LAT      = DELAYS + N_NEUR + 7;

   logic                 clk = 1'b0;
   logic                 rst = 1'b1;
   logic                 x_valid = 1'b0;
   logic [DW-1:0]        x_data = '0;
   logic                 x_ready;
   logic                 y_valid;
   logic [DW-1:0]        y_data;
   logic                 y_ready = 1'b0;
   logic [WAW-1:0]       w_addr;
   logic [N_NEUR*DW-1:0] w_data = '0;
   logic [DW-1:0]        t_addr;
   logic [DW-1:0]        t_data = '0;

   logic [N_NEUR*DW-1:0] rom [DELAYS+3];
   logic [DW-1:0]        lut [256];
   int                   wt  [DELAYS+3][N_NEUR];
   int                   hist [DELAYS];
   int                   checks = 0;
   int                   errors = 0;

   narnet_param_engine #(
      .DW       (DW),
      .FRAC     (FRAC),
      .N_NEUR   (N_NEUR),
      .DELAYS   (DELAYS),
      .INIT_VAL (INIT_VAL)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .x_valid (x_valid),
      .x_data  (x_data),
      .x_ready (x_ready),
      .y_valid (y_valid),
      .y_data  (y_data),
      .y_ready (y_ready),
      .w_addr  (w_addr),
      .w_data  (w_data),
      .t_addr  (t_addr),
      .t_data  (t_data)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      w_data <= (int'(w_addr) < DELAYS + 3) ? rom[w_addr] : '0;
      t_data <= lut[t_addr];
   end

   task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   function automatic int red(input int v);
`ifdef NARNET_SAT_EN
      if (v > 127) return 127;
      if (v < -128) return -128;
      return v;
`else
      int r;
      r = v & 255;
      return (r >= 128) ? r - 256 : r;
`endif
   endfunction

   function automatic int lutv(input int pre);
      logic [7:0] a;
      a = 8'(pre);
      return int'($signed(lut[a]));
   endfunction

   // Reference: history[k] is the sample k transfers ago, network evaluated directly
   task automatic model_step(input int x, output int y);
      int s;
      int o;
      int a [N_NEUR];
      for (int k = DELAYS - 1; k > 0; k--)
         hist[k] = hist[k-1];
      hist[0] = x;
      for (int n = 0; n < N_NEUR; n++) begin
         s = wt[DELAYS][n];
         for (int k = 0; k < DELAYS; k++)
            s += (hist[k] * wt[k][n]) >>> FRAC;
         a[n] = lutv(red(s));
      end
      o = wt[DELAYS+2][0];
      for (int n = 0; n < N_NEUR; n++)
         o += (a[n] * wt[DELAYS+1][n]) >>> FRAC;
      y = red(o);
   endtask

   task automatic build_rom();
      logic [31:0] tmp;
      for (int r = 0; r < DELAYS + 3; r++)
         for (int n = 0; n < N_NEUR; n++) begin
            tmp = 32'(wt[r][n]);
            rom[r][n*DW +: DW] = tmp[DW-1:0];
         end
   endtask

   task automatic clear_wt();
      for (int r = 0; r < DELAYS + 3; r++)
         for (int n = 0; n < N_NEUR; n++)
            wt[r][n] = 0;
   endtask

   task automatic lut_identity();
      for (int a = 0; a < 256; a++)
         lut[a] = 8'(a);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      x_valid = 1'b0;
      y_ready = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      for (int k = 0; k < DELAYS; k++)
         hist[k] = INIT_VAL;
   endtask

   task automatic send(input int x, input int hold);
      int exp;
      int lat;
      model_step(x, exp);
      @(negedge clk);
      chk("x_ready_idle", x_ready, 1);
      x_valid = 1'b1;
      x_data  = 8'(x);
      @(posedge clk);
      #1;
      x_data = 8'($urandom);   // kept valid with junk: must be ignored while busy
      chk("x_ready_busy", x_ready, 0);
      lat = 0;
      do begin
         @(posedge clk);
         #1;
         lat++;
      end while (y_valid !== 1'b1 && lat < LAT + 20);
      chk("latency", lat, LAT);
      chk("y_data", $signed(y_data), exp);
      for (int h = 0; h < hold; h++) begin
         @(posedge clk);
         #1;
         chk("hold_y_valid", y_valid, 1);
         chk("hold_y_data", $signed(y_data), exp);
         chk("hold_x_ready", x_ready, 0);
      end
      y_ready = 1'b1;
      x_valid = 1'b0;
      @(posedge clk);
      #1;
      y_ready = 1'b0;
      chk("y_valid_drop", y_valid, 0);
      chk("x_ready_back", x_ready, 1);
   endtask

   initial begin
      int seen;
      clear_wt();
      build_rom();
      lut_identity();

      // reset state
      do_reset();
      chk("rst_x_ready", x_ready, 1);
      chk("rst_y_valid", y_valid, 0);
      chk("rst_y_data", y_data, 0);
      chk("rst_w_addr", w_addr, 0);
      chk("rst_t_addr", t_addr, 0);

      // all-zero ROM
      send(64, 0);

      // biases only, output overflow, 10-cycle backpressure
      clear_wt();
      for (int n = 0; n < N_NEUR; n++) begin
         wt[DELAYS][n]   = 64;
         wt[DELAYS+1][n] = 64;
      end
      build_rom();
      send(0, 10);

      // identity path through tap 0, pointer wraps past DELAYS
      do_reset();
      clear_wt();
      for (int n = 0; n < N_NEUR; n++)
         wt[0][n] = 64;
      wt[DELAYS+1][0] = 64;
      build_rom();
      for (int i = 1; i <= 40; i++)
         send(i, 0);

      // oldest tap only: INIT_VAL until the line fills
      do_reset();
      clear_wt();
      for (int n = 0; n < N_NEUR; n++)
         wt[DELAYS-1][n] = 64;
      wt[DELAYS+1][0] = 64;
      build_rom();
      for (int i = 1; i <= DELAYS + 1; i++)
         send(i, 0);

      // reset during L1 cycle 5
      @(negedge clk);
      x_valid = 1'b1;
      x_data  = 8'(77);
      @(posedge clk);
      #1;
      x_valid = 1'b0;
      repeat (6) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      for (int k = 0; k < DELAYS; k++)
         hist[k] = INIT_VAL;
      chk("abort_x_ready", x_ready, 1);
      chk("abort_y_valid", y_valid, 0);
      seen = 0;
      repeat (LAT + 5) begin
         @(posedge clk);
         #1;
         if (y_valid === 1'b1)
            seen++;
      end
      chk("abort_no_y", seen, 0);
      send(5, 0);
      send(6, 1);

      // randomized weights, LUT contents and samples
      do_reset();
      for (int r = 0; r < DELAYS + 3; r++)
         for (int n = 0; n < N_NEUR; n++)
            wt[r][n] = int'($urandom_range(0, 127)) - 64;
      build_rom();
      for (int a = 0; a < 256; a++)
         lut[a] = 8'($urandom);
      for (int i = 0; i < 24; i++)
         send(int'($urandom_range(0, 255)) - 128, int'($urandom_range(0, 3)));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
